// File: rtl/fft_iter_param.sv
// -----------------------------------------------------------------------------
// fft_iter_param
//
// In-place iterative radix-2 decimation-in-frequency FFT/IFFT engine of
// N = 2**LOG2N complex points. A frame is streamed in natural order, then
// transformed in place one butterfly at a time (4 cycles per butterfly), then
// streamed out in natural order by reading the RAM at bit-reversed addresses.
// Optional per-stage 1/2 scaling; every butterfly output saturates to DW bits
// and any clip raises a sticky overflow flag for the frame.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is only high in LOAD; in_valid is ignored otherwise.
// While out_valid is high and out_ready is low, out_re/out_im/out_last/
// out_valid hold their values.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input sample handshake
//   in_re, in_im        signed input sample (natural order)
//   inverse             1 = IFFT (conjugate twiddles), taken with sample 0
//   scale_en            1 = >>>1 on both butterfly outputs, taken with sample 0
//   out_valid/out_ready output bin handshake
//   out_re, out_im      signed output bin (natural order)
//   out_last            high with bin N-1
//   busy                high while computing or unloading
//   overflow            sticky saturation flag, cleared by the next sample 0
// -----------------------------------------------------------------------------
module fft_iter_param #(
   parameter int LOG2N = 9,
   parameter int DW    = 16,
   parameter int TW_W  = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   input  logic          inverse,
   input  logic          scale_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic          out_last,
   output logic          busy,
   output logic          overflow
);

   localparam int N  = 1 << LOG2N;
   localparam int HN = N / 2;
   localparam int AW = LOG2N;       // RAM address width
   localparam int BW = LOG2N - 1;   // butterfly counter / twiddle index width
   localparam int SW = DW + 1;      // sum/difference width
   localparam int PW = SW + TW_W + 1; // complex product sum width

   localparam logic signed [PW-1:0] RND     = PW'(2 ** (TW_W - 2));
   localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DW - 1) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

   localparam real PI = 3.14159265358979323846;

   // ---------------------------------------------------------------------------
   // Twiddle ROM: W(idx) = cos - j*sin of 2*pi*idx/N, scaled by 2**(TW_W-1)-1
   // and rounded to nearest. Built at elaboration for the chosen LOG2N.
   // ---------------------------------------------------------------------------
   function automatic logic [TW_W-1:0] tw_gen(input int idx, input bit is_sin);
      real ang;
      real amp;
      real v;
      ang = 2.0 * PI * real'(idx) / real'(N);
      amp = (2.0 ** (TW_W - 1)) - 1.0;
      v   = is_sin ? -$sin(ang) * amp : $cos(ang) * amp;
      v   = (v >= 0.0) ? $floor(v + 0.5) : $ceil(v - 0.5);
      return TW_W'($rtoi(v));
   endfunction

   logic [TW_W-1:0] rom_wr [HN];
   logic [TW_W-1:0] rom_wi [HN];

   for (genvar g = 0; g < HN; g++) begin : g_rom
      assign rom_wr[g] = tw_gen(g, 1'b0);
      assign rom_wi[g] = tw_gen(g, 1'b1);
   end

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) begin
         r[AW-1-i] = v[i];
      end
      return r;
   endfunction

   // Saturate to DW bits; bit DW of the result flags a clip.
   function automatic logic [DW:0] sat(input logic signed [PW-1:0] v);
      if (v > SAT_MAX) begin
         return {1'b1, SAT_MAX[DW-1:0]};
      end else if (v < SAT_MIN) begin
         return {1'b1, SAT_MIN[DW-1:0]};
      end else begin
         return {1'b0, v[DW-1:0]};
      end
   endfunction

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_LOAD,
      S_FETCH,
      S_MULT,
      S_STORE,
      S_NEXT,
      S_UNLOAD
   } state_t;

   state_t        state;
   logic [AW-1:0] k;        // load address
   logic [AW-1:0] m;        // unload bin index
   logic [BW-1:0] bf;       // butterfly number within the stage
   logic [3:0]    stg;      // stage number minus one
   logic          inv_q;
   logic          scl_q;

   logic [DW-1:0] mem_re [N];
   logic [DW-1:0] mem_im [N];

   logic [DW-1:0] a_re, a_im, b_re, b_im;
   logic [DW-1:0] y0_re, y0_im, y1_re, y1_im;

   // ---------------------------------------------------------------------------
   // Butterfly addressing. dist = 2**(LOG2N-1-stg); mask = dist-1 selects j out
   // of bf, the remaining high bits of bf select the group, which is then
   // shifted up by one to step groups by 2*dist.
   // ---------------------------------------------------------------------------
   logic [BW-1:0] mask;
   logic [BW-1:0] j_idx;
   logic [BW-1:0] tw_idx;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [AW-1:0] m_next;
   logic [AW-1:0] rd_addr;

   always_comb begin
      mask    = BW'(HN - 1) >> stg;
      j_idx   = bf & mask;
      addr_a  = {bf & ~mask, 1'b0} | {1'b0, j_idx};
      addr_b  = addr_a | ({1'b0, mask} + AW'(1));
      tw_idx  = j_idx << stg;
      m_next  = m + AW'(1);
      rd_addr = bitrev(m_next);
   end

   // ---------------------------------------------------------------------------
   // Butterfly arithmetic: y0 = a+b, y1 = (a-b)*W with round-half-up products.
   // ---------------------------------------------------------------------------
   logic signed [TW_W-1:0] wr;
   logic signed [TW_W-1:0] wi;
   logic signed [SW-1:0]   sum_re, sum_im, dif_re, dif_im;
   logic signed [PW-1:0]   pr_re, pr_im;
   logic signed [PW-1:0]   r_re, r_im;
   logic signed [PW-1:0]   s0_re, s0_im, s1_re, s1_im;
   logic [DW:0]            q0_re, q0_im, q1_re, q1_im;
   logic                   clip;

   always_comb begin
      wr     = $signed(rom_wr[tw_idx]);
      // Conjugating the twiddle turns the forward transform into the inverse.
      wi     = inv_q ? -$signed(rom_wi[tw_idx]) : $signed(rom_wi[tw_idx]);
      sum_re = $signed({a_re[DW-1], a_re}) + $signed({b_re[DW-1], b_re});
      sum_im = $signed({a_im[DW-1], a_im}) + $signed({b_im[DW-1], b_im});
      dif_re = $signed({a_re[DW-1], a_re}) - $signed({b_re[DW-1], b_re});
      dif_im = $signed({a_im[DW-1], a_im}) - $signed({b_im[DW-1], b_im});
      pr_re  = PW'(dif_re) * PW'(wr) - PW'(dif_im) * PW'(wi);
      pr_im  = PW'(dif_re) * PW'(wi) + PW'(dif_im) * PW'(wr);
      r_re   = (pr_re + RND) >>> (TW_W - 1);
      r_im   = (pr_im + RND) >>> (TW_W - 1);
      s0_re  = scl_q ? (PW'(sum_re) >>> 1) : PW'(sum_re);
      s0_im  = scl_q ? (PW'(sum_im) >>> 1) : PW'(sum_im);
      s1_re  = scl_q ? (r_re >>> 1) : r_re;
      s1_im  = scl_q ? (r_im >>> 1) : r_im;
      q0_re  = sat(s0_re);
      q0_im  = sat(s0_im);
      q1_re  = sat(s1_re);
      q1_im  = sat(s1_im);
      clip   = q0_re[DW] | q0_im[DW] | q1_re[DW] | q1_im[DW];
   end

   // ---------------------------------------------------------------------------
   // Sample RAM: written by the load stream and by butterfly STORE. Contents
   // are not reset; every frame overwrites all N entries before use.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (state == S_LOAD && in_valid && in_ready) begin
         mem_re[k] <= in_re;
         mem_im[k] <= in_im;
      end
      if (state == S_STORE) begin
         mem_re[addr_a] <= y0_re;
         mem_im[addr_a] <= y0_im;
         mem_re[addr_b] <= y1_re;
         mem_im[addr_b] <= y1_im;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOAD;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         k         <= '0;
         m         <= '0;
         bf        <= '0;
         stg       <= '0;
         inv_q     <= 1'b0;
         scl_q     <= 1'b0;
         a_re      <= '0;
         a_im      <= '0;
         b_re      <= '0;
         b_im      <= '0;
         y0_re     <= '0;
         y0_im     <= '0;
         y1_re     <= '0;
         y1_im     <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid && in_ready) begin
                  if (k == '0) begin
                     inv_q    <= inverse;
                     scl_q    <= scale_en;
                     overflow <= 1'b0;
                  end
                  if (k == AW'(N - 1)) begin
                     k        <= '0;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     bf       <= '0;
                     stg      <= '0;
                     state    <= S_FETCH;
                  end else begin
                     k <= k + AW'(1);
                  end
               end else begin
                  // Covers the first cycle after reset, when in_ready is low.
                  in_ready <= 1'b1;
               end
            end

            S_FETCH: begin
               a_re  <= mem_re[addr_a];
               a_im  <= mem_im[addr_a];
               b_re  <= mem_re[addr_b];
               b_im  <= mem_im[addr_b];
               state <= S_MULT;
            end

            S_MULT: begin
               y0_re <= q0_re[DW-1:0];
               y0_im <= q0_im[DW-1:0];
               y1_re <= q1_re[DW-1:0];
               y1_im <= q1_im[DW-1:0];
               if (clip) begin
                  overflow <= 1'b1;
               end
               state <= S_STORE;
            end

            S_STORE: begin
               state <= S_NEXT;
            end

            S_NEXT: begin
               if (bf == BW'(HN - 1)) begin
                  bf <= '0;
                  if (stg == 4'(LOG2N - 1)) begin
                     // Bin 0 lives at bitrev(0) = 0; the last STORE has
                     // already landed, so it can be presented right away.
                     state     <= S_UNLOAD;
                     out_valid <= 1'b1;
                     out_last  <= 1'b0;
                     m         <= '0;
                     out_re    <= mem_re[0];
                     out_im    <= mem_im[0];
                  end else begin
                     stg   <= stg + 4'd1;
                     state <= S_FETCH;
                  end
               end else begin
                  bf    <= bf + BW'(1);
                  state <= S_FETCH;
               end
            end

            S_UNLOAD: begin
               if (out_ready) begin
                  if (m == AW'(N - 1)) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     m         <= '0;
                     state     <= S_LOAD;
                  end else begin
                     m        <= m_next;
                     out_re   <= mem_re[rd_addr];
                     out_im   <= mem_im[rd_addr];
                     out_last <= (m_next == AW'(N - 1));
                  end
               end
            end

            default: begin
               state <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_iter_param.sv
module tb_fft_iter_param;

   logic clk;
   logic reset;

   // 8-point instance
   logic        a_in_valid, a_in_ready, a_inverse, a_scale_en;
   logic [15:0] a_in_re, a_in_im, a_out_re, a_out_im;
   logic        a_out_valid, a_out_ready, a_out_last, a_busy, a_overflow;

   // 512-point instance
   logic        b_in_valid, b_in_ready, b_inverse, b_scale_en;
   logic [15:0] b_in_re, b_in_im, b_out_re, b_out_im;
   logic        b_out_valid, b_out_ready, b_out_last, b_busy, b_overflow;

   fft_iter_param #(.LOG2N(3), .DW(16), .TW_W(16)) u_dut8 (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_re(a_in_re), .in_im(a_in_im),
      .inverse(a_inverse), .scale_en(a_scale_en),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_re(a_out_re), .out_im(a_out_im), .out_last(a_out_last),
      .busy(a_busy), .overflow(a_overflow)
   );

   fft_iter_param #(.LOG2N(9), .DW(16), .TW_W(16)) u_dut512 (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_re(b_in_re), .in_im(b_in_im),
      .inverse(b_inverse), .scale_en(b_scale_en),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_re(b_out_re), .out_im(b_out_im), .out_last(b_out_last),
      .busy(b_busy), .overflow(b_overflow)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] vec_re [8];
   logic [15:0] vec_im [8];
   int          exp_re [8];
   int          exp_im [8];
   int          got_re [8];
   int          got_im [8];
   int          got_last [8];

   task automatic check_val(input string tag, input int obs, input int exp_v, input int tol);
      n_tests++;
      if (obs < exp_v - tol || obs > exp_v + tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp_v, tol);
      end
   endtask

   task automatic set_vec(input int re, input int im);
      for (int i = 0; i < 8; i++) begin
         vec_re[i] = 16'(re);
         vec_im[i] = 16'(im);
      end
   endtask

   task automatic set_exp(input int re_all, input int peak, input int peak_re);
      for (int i = 0; i < 8; i++) begin
         exp_re[i] = re_all;
         exp_im[i] = 0;
      end
      if (peak >= 0) exp_re[peak] = peak_re;
   endtask

   // ---------------- drivers (8-point) ----------------
   // Entered and left at #1 after a rising edge.
   task automatic load_a(input int k0, input int k1);
      int wait_cyc;
      for (int k = k0; k <= k1; k++) begin
         a_in_valid = 1'b1;
         a_in_re    = vec_re[k];
         a_in_im    = vec_im[k];
         wait_cyc   = 0;
         while (!a_in_ready && wait_cyc < 1000) begin
            @(posedge clk); #1;
            wait_cyc++;
         end
         if (wait_cyc >= 1000) begin
            check_val("load_a_timeout", 0, 1, 0);
            a_in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
   endtask

   task automatic unload_a();
      int wait_cyc;
      a_out_ready = 1'b1;
      for (int m = 0; m < 8; m++) begin
         wait_cyc = 0;
         while (!a_out_valid && wait_cyc < 1000) begin
            @(posedge clk); #1;
            wait_cyc++;
         end
         if (wait_cyc >= 1000) begin
            check_val("unload_a_timeout", 0, 1, 0);
            return;
         end
         got_re[m]   = int'($signed(a_out_re));
         got_im[m]   = int'($signed(a_out_im));
         got_last[m] = int'(a_out_last);
         @(posedge clk); #1;
      end
   endtask

   task automatic check_bins(input string tag, input int tol);
      for (int m = 0; m < 8; m++) begin
         check_val($sformatf("%s_re%0d", tag, m), got_re[m], exp_re[m], tol);
         check_val($sformatf("%s_im%0d", tag, m), got_im[m], exp_im[m], tol);
         check_val($sformatf("%s_last%0d", tag, m), got_last[m], (m == 7) ? 1 : 0, 0);
      end
   endtask

   // ---------------- drivers (512-point, impulse only) ----------------
   task automatic load_b();
      int wait_cyc;
      for (int k = 0; k < 512; k++) begin
         b_in_valid = 1'b1;
         b_in_re    = (k == 0) ? 16'd1000 : 16'd0;
         b_in_im    = 16'd0;
         wait_cyc   = 0;
         while (!b_in_ready && wait_cyc < 1000) begin
            @(posedge clk); #1;
            wait_cyc++;
         end
         if (wait_cyc >= 1000) begin
            check_val("load_b_timeout", 0, 1, 0);
            b_in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
   endtask

   task automatic unload_b(input bit bp, input string tag);
      int          hs;
      int          cyc;
      bit          prev_stall;
      logic [15:0] p_re, p_im;
      logic        p_last;
      hs = 0; cyc = 0; prev_stall = 1'b0;
      p_re = '0; p_im = '0; p_last = 1'b0;
      while (hs < 512 && cyc < 30000) begin
         if (prev_stall) begin
            check_val({tag, "_stall_valid"}, int'(b_out_valid), 1, 0);
            check_val({tag, "_stall_re"}, int'($signed(b_out_re)), int'($signed(p_re)), 0);
            check_val({tag, "_stall_im"}, int'($signed(b_out_im)), int'($signed(p_im)), 0);
            check_val({tag, "_stall_last"}, int'(b_out_last), int'(p_last), 0);
         end
         b_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (b_out_valid && b_out_ready) begin
            hs++;
            check_val($sformatf("%s_re%0d", tag, hs - 1), int'($signed(b_out_re)), 1000, 1);
            check_val($sformatf("%s_im%0d", tag, hs - 1), int'($signed(b_out_im)), 0, 1);
            check_val($sformatf("%s_last%0d", tag, hs - 1), int'(b_out_last), (hs == 512) ? 1 : 0, 0);
         end
         prev_stall = b_out_valid && !b_out_ready;
         p_re   = b_out_re;
         p_im   = b_out_im;
         p_last = b_out_last;
         @(posedge clk); #1;
         cyc++;
      end
      check_val({tag, "_handshakes"}, hs, 512, 0);
      check_val({tag, "_out_valid_after"}, int'(b_out_valid), 0, 0);
      check_val({tag, "_in_ready_after"}, int'(b_in_ready), 1, 0);
      b_out_ready = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cnt;
      int rises;
      reset = 1'b1;
      a_in_valid = 0; a_in_re = 0; a_in_im = 0; a_inverse = 0; a_scale_en = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_re = 0; b_in_im = 0; b_inverse = 0; b_scale_en = 0; b_out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      // Reset values
      check_val("rst_in_ready", int'(a_in_ready), 0, 0);
      check_val("rst_out_valid", int'(a_out_valid), 0, 0);
      check_val("rst_out_last", int'(a_out_last), 0, 0);
      check_val("rst_busy", int'(a_busy), 0, 0);
      check_val("rst_overflow", int'(a_overflow), 0, 0);
      check_val("rst_out_re", int'(a_out_re), 0, 0);
      check_val("rst_out_im", int'(a_out_im), 0, 0);
      check_val("rst_b_in_ready", int'(b_in_ready), 0, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check_val("post_rst_in_ready", int'(a_in_ready), 1, 0);
      check_val("post_rst_b_in_ready", int'(b_in_ready), 1, 0);

      // Impulse, no scaling: flat spectrum of 1000
      set_vec(0, 0); vec_re[0] = 16'd1000;
      a_inverse = 0; a_scale_en = 0;
      load_a(0, 7);
      unload_a();
      set_exp(1000, -1, 0);
      check_bins("imp", 1);
      check_val("imp_overflow", int'(a_overflow), 0, 0);

      // DC with scaling, plus compute length
      set_vec(4096, 0);
      a_scale_en = 1;
      load_a(0, 7);
      check_val("dc_in_ready_low", int'(a_in_ready), 0, 0);
      check_val("dc_busy", int'(a_busy), 1, 0);
      cnt = 0;
      while (!a_out_valid && cnt < 1000) begin
         @(posedge clk); #1;
         cnt++;
      end
      check_val("dc_compute_len", cnt, 48, 0);
      unload_a();
      set_exp(0, 0, 4096);
      check_bins("dc", 2);

      // Tone at bin 1: x[n] = 8192*exp(j*2*pi*n/8)
      vec_re[0] = 16'(8192);  vec_im[0] = 16'(0);
      vec_re[1] = 16'(5793);  vec_im[1] = 16'(5793);
      vec_re[2] = 16'(0);     vec_im[2] = 16'(8192);
      vec_re[3] = 16'(-5793); vec_im[3] = 16'(5793);
      vec_re[4] = 16'(-8192); vec_im[4] = 16'(0);
      vec_re[5] = 16'(-5793); vec_im[5] = 16'(-5793);
      vec_re[6] = 16'(0);     vec_im[6] = 16'(-8192);
      vec_re[7] = 16'(5793);  vec_im[7] = 16'(-5793);
      a_inverse = 0; a_scale_en = 1;
      load_a(0, 7);
      unload_a();
      set_exp(0, 1, 8192);
      check_bins("tone_fwd", 2);
      check_val("tone_fwd_overflow", int'(a_overflow), 0, 0);

      a_inverse = 1;
      load_a(0, 7);
      unload_a();
      set_exp(0, 7, 8192);
      check_bins("tone_inv", 2);

      // Saturation: clip at every stage, sticky overflow
      set_vec(20000, 0);
      a_inverse = 0; a_scale_en = 0;
      load_a(0, 7);
      unload_a();
      set_exp(0, 0, 32767);
      check_bins("sat", 0);
      check_val("sat_overflow", int'(a_overflow), 1, 0);
      set_vec(0, 0); vec_re[0] = 16'd1000;
      load_a(0, 0);
      check_val("sat_ovf_cleared", int'(a_overflow), 0, 0);
      load_a(1, 7);
      unload_a();
      set_exp(1000, -1, 0);
      check_bins("post_sat", 1);
      check_val("post_sat_overflow", int'(a_overflow), 0, 0);

      // 512-point impulse with random output backpressure
      load_b();
      unload_b(1'b1, "bp");

      // Reset 100 cycles into compute
      load_b();
      check_val("rc_busy", int'(b_busy), 1, 0);
      repeat (100) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check_val("rc_in_ready", int'(b_in_ready), 1, 0);
      check_val("rc_busy_low", int'(b_busy), 0, 0);
      rises = 0;
      repeat (300) begin
         if (b_out_valid) rises++;
         @(posedge clk); #1;
      end
      check_val("rc_no_out_valid", rises, 0, 0);
      load_b();
      unload_b(1'b0, "rc_frame");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
